// File: rtl/axis_stream_arbiter_if.sv
// Bundles the N producer streams, the shared consumer stream and the arbiter status.
// The arbiter connects through the master modport; the surrounding fabric uses slave.
interface axis_stream_arbiter_if #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = $clog2(N_SRC)
);
  localparam int unsigned CNT_W = 16;

  logic [N_SRC-1:0]        s_valid;
  logic [N_SRC*DATA_W-1:0] s_data;
  logic [N_SRC-1:0]        s_last;
  logic [N_SRC-1:0]        s_ready;
  logic                    m_valid;
  logic [DATA_W-1:0]       m_data;
  logic                    m_last;
  logic                    m_ready;
  logic [ID_W-1:0]         m_id;
  logic                    busy;
  logic [CNT_W-1:0]        pkt_cnt;

  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_id, busy, pkt_cnt
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_id, busy, pkt_cnt
  );
endinterface

// File: rtl/axis_stream_arbiter.sv
// Packet-level round-robin arbiter: one grant is held from the first beat through
// the last beat of a packet, so packets from different sources never interleave.
module axis_stream_arbiter #(
  parameter int unsigned N_SRC  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = $clog2(N_SRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_stream_arbiter_if.master bus
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic              busy_q, busy_d;

  logic              any_req_c;
  logic [ID_W-1:0]   winner_c;
  logic              m_valid_c;
  logic              m_last_c;
  logic [DATA_W-1:0] m_data_c;
  logic [N_SRC-1:0]  s_ready_c;
  logic              last_xfer_c;

  // Round-robin search starting just above the previous winner, wrapping modulo N_SRC.
  always_comb begin
    any_req_c = 1'b0;
    winner_c  = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      if (!any_req_c && bus.s_valid[ID_W'((32'(last_grant_q) + k) % N_SRC)]) begin
        any_req_c = 1'b1;
        winner_c  = ID_W'((32'(last_grant_q) + k) % N_SRC);
      end
    end
  end

  // Zero-latency path from the granted source to the shared slave.
  always_comb begin
    m_valid_c = 1'b0;
    m_last_c  = 1'b0;
    m_data_c  = '0;
    s_ready_c = '0;
    if (state_q == ST_BUSY) begin
      m_valid_c          = bus.s_valid[grant_q];
      m_last_c           = bus.s_last[grant_q];
      m_data_c           = bus.s_data[32'(grant_q) * DATA_W +: DATA_W];
      s_ready_c[grant_q] = bus.m_ready;
    end
  end

  assign last_xfer_c = m_valid_c & bus.m_ready & m_last_c;

  // Next-state: grant in IDLE, release only on the accepted last beat.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_cnt_d    = pkt_cnt_q;
    busy_d       = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          state_d      = ST_BUSY;
          grant_d      = winner_c;
          last_grant_d = winner_c;
          busy_d       = 1'b1;
        end
      end
      ST_BUSY: begin
        if (last_xfer_c) begin
          state_d   = ST_IDLE;
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(N_SRC - 1);
      pkt_cnt_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_cnt_q    <= pkt_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.m_valid = m_valid_c;
  assign bus.m_last  = m_last_c;
  assign bus.m_data  = m_data_c;
  assign bus.s_ready = s_ready_c;
  assign bus.m_id    = grant_q;
  assign bus.busy    = busy_q;
  assign bus.pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// Directed bench for axis_stream_arbiter: packet-level behavioural model checked
// every cycle, plus literal expectations for each scenario.
module tb_axis_stream_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IDW = 2;
  localparam int QD  = 16;
  localparam int LG  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_stream_arbiter_if #(.N_SRC(N), .DATA_W(DW), .ID_W(IDW)) bus ();
  axis_stream_arbiter #(.N_SRC(N), .DATA_W(DW), .ID_W(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Source-side beat queues: {last, data}
  logic [8:0] mem [N][QD];
  int   head [N];
  int   tail [N];
  logic en   [N];
  logic fire [N];
  logic mrdy  = 1'b1;
  logic rst_nx = 1'b1;

  // Behavioural model: owner of the output (-1 = none), priority pointer, id, count
  int          own   = -1;
  int          plast = N - 1;
  int          mid   = 0;
  logic [15:0] mcnt  = '0;
  bit          mdl_ok = 1'b0;

  int lg_cyc [LG];
  int lg_src [LG];
  int lg_dat [LG];
  int nlg = 0;
  int gr [LG];
  int ngr = 0;
  int t0  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int s, input int d, input bit l);
    if (tail[s] < QD) begin
      mem[s][tail[s]] = {l, 8'(d)};
      tail[s]++;
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      fire[i] = 1'b0;
      en[i]   = 1'b1;
    end
  endtask

  task automatic clear_logs();
    nlg = 0;
    ngr = 0;
  endtask

  task automatic drive();
    rst = rst_nx;
    for (int i = 0; i < N; i++) begin
      logic has;
      has = head[i] < tail[i];
      bus.s_valid[i]         = en[i] & has;
      bus.s_data[i*DW +: DW] = has ? mem[i][head[i]][7:0] : 8'h00;
      bus.s_last[i]          = has ? mem[i][head[i]][8] : 1'b0;
    end
    bus.m_ready = mrdy;
  endtask

  task automatic compare_all();
    logic [N-1:0]  e_rdy;
    logic          e_v;
    logic          e_l;
    logic [DW-1:0] e_d;
    e_rdy = '0;
    e_v   = 1'b0;
    e_l   = 1'b0;
    e_d   = '0;
    if (own >= 0) begin
      e_v        = bus.s_valid[own];
      e_l        = bus.s_last[own];
      e_d        = bus.s_data[own*DW +: DW];
      e_rdy[own] = bus.m_ready;
    end
    chk("m_valid", 32'(bus.m_valid), 32'(e_v));
    chk("m_last",  32'(bus.m_last),  32'(e_l));
    chk("m_data",  32'(bus.m_data),  32'(e_d));
    chk("s_ready", 32'(bus.s_ready), 32'(e_rdy));
    chk("m_id",    32'(bus.m_id),    mid);
    chk("busy",    32'(bus.busy),    (own >= 0) ? 1 : 0);
    chk("pkt_cnt", 32'(bus.pkt_cnt), 32'(mcnt));
  endtask

  // Advance the model by one clock using the inputs the DUT will sample.
  task automatic model_step();
    if (rst) begin
      own    = -1;
      plast  = N - 1;
      mid    = 0;
      mcnt   = '0;
      mdl_ok = 1'b1;
    end else if (own < 0) begin
      int win;
      win = -1;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (plast + k) % N;
        if (win < 0 && bus.s_valid[i]) win = i;
      end
      if (win >= 0) begin
        own   = win;
        plast = win;
        mid   = win;
        if (ngr < LG) begin
          gr[ngr] = win;
          ngr++;
        end
      end
    end else if (bus.s_valid[own] && bus.m_ready) begin
      if (nlg < LG) begin
        lg_cyc[nlg] = cyc;
        lg_src[nlg] = own;
        lg_dat[nlg] = 32'(bus.s_data[own*DW +: DW]);
        nlg++;
      end
      if (bus.s_last[own]) begin
        mcnt = mcnt + 16'd1;
        own  = -1;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    cyc++;
    if (mdl_ok) compare_all();
    for (int i = 0; i < N; i++) fire[i] = bus.s_valid[i] & bus.s_ready[i];
    model_step();
  endtask

  task automatic at_pos();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (fire[i]) head[i]++;
    drive();
  endtask

  task automatic step();
    at_pos();
    at_neg();
  endtask

  task automatic do_reset();
    rst_nx = 1'b1;
    step();
    clear_q();
    clear_logs();
    rst_nx = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e2c [10];
    int e2s [5];
    int e3c [6];
    int e3s [6];
    e2s = '{0, 1, 2, 3, 0};
    e3c = '{1, 2, 6, 7, 9, 10};
    e3s = '{2, 2, 2, 2, 1, 1};
    for (int k = 0; k < 10; k++) e2c[k] = 1 + (k / 2) * 3 + (k % 2);

    clear_q();
    rst_nx = 1'b1;
    mrdy   = 1'b1;
    drive();
    at_neg();

    // Single 3-beat packet from source 0
    do_reset();
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b0);
    push(0, 8'h33, 1'b1);
    step();
    t0 = cyc;
    chk("t1_reset_busy", 32'(bus.busy), 0);
    chk("t1_reset_cnt", 32'(bus.pkt_cnt), 0);
    repeat (4) step();
    chk("t1_cnt", 32'(bus.pkt_cnt), 1);
    chk("t1_idle_busy", 32'(bus.busy), 0);
    chk("t1_nbeats", nlg, 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_beat_cyc", lg_cyc[k] - t0, k + 1);
      chk("t1_beat_src", lg_src[k], 0);
    end
    chk("t1_d0", lg_dat[0], 8'h11);
    chk("t1_d1", lg_dat[1], 8'h22);
    chk("t1_d2", lg_dat[2], 8'h33);

    // All sources requesting 2-beat packets
    do_reset();
    for (int s = 0; s < N; s++) begin
      push(s, s * 16 + 1, 1'b0);
      push(s, s * 16 + 2, 1'b1);
    end
    push(0, 8'h05, 1'b0);
    push(0, 8'h06, 1'b1);
    step();
    t0 = cyc;
    repeat (16) step();
    chk("t2_ngrants", ngr, 5);
    for (int k = 0; k < 5; k++) chk("t2_grant_order", gr[k], e2s[k]);
    chk("t2_nbeats", nlg, 10);
    for (int k = 0; k < 10; k++) begin
      chk("t2_beat_cyc", lg_cyc[k] - t0, e2c[k]);
      chk("t2_beat_src", lg_src[k], e2s[k / 2]);
    end
    chk("t2_cnt", 32'(bus.pkt_cnt), 5);

    // Granted source 2 stalls while source 1 waits
    do_reset();
    push(2, 8'h20, 1'b0);
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h23, 1'b1);
    step();
    t0 = cyc;
    step();
    step();
    en[2] = 1'b0;
    push(1, 8'h30, 1'b0);
    push(1, 8'h31, 1'b1);
    repeat (3) begin
      step();
      chk("t3_bubble_valid", 32'(bus.m_valid), 0);
      chk("t3_bubble_id", 32'(bus.m_id), 2);
      chk("t3_bubble_rdy1", 32'(bus.s_ready[1]), 0);
    end
    en[2] = 1'b1;
    step();
    step();
    chk("t3_last_rdy1", 32'(bus.s_ready[1]), 0);
    step();
    chk("t3_idle_rdy", 32'(bus.s_ready), 0);
    chk("t3_idle_busy", 32'(bus.busy), 0);
    step();
    chk("t3_next_id", 32'(bus.m_id), 1);
    chk("t3_next_rdy", 32'(bus.s_ready), 4'b0010);
    step();
    step();
    chk("t3_nbeats", nlg, 6);
    for (int k = 0; k < 6; k++) begin
      chk("t3_beat_cyc", lg_cyc[k] - t0, e3c[k]);
      chk("t3_beat_src", lg_src[k], e3s[k]);
    end
    chk("t3_cnt", 32'(bus.pkt_cnt), 2);

    // Backpressure on a 2-beat packet from source 3
    do_reset();
    push(3, 8'hA1, 1'b0);
    push(3, 8'hB2, 1'b1);
    step();
    t0 = cyc;
    mrdy = 1'b1;
    step();
    chk("t4_b1_rdy", 32'(bus.s_ready), 4'b1000);
    chk("t4_b1_data", 32'(bus.m_data), 8'hA1);
    mrdy = 1'b0;
    repeat (2) begin
      step();
      chk("t4_hold_data", 32'(bus.m_data), 8'hB2);
      chk("t4_hold_valid", 32'(bus.m_valid), 1);
      chk("t4_hold_rdy", 32'(bus.s_ready), 0);
    end
    mrdy = 1'b1;
    step();
    chk("t4_b2_rdy", 32'(bus.s_ready), 4'b1000);
    chk("t4_b2_last", 32'(bus.m_last), 1);
    step();
    chk("t4_nxfers", nlg, 2);
    chk("t4_x0_cyc", lg_cyc[0] - t0, 1);
    chk("t4_x1_cyc", lg_cyc[1] - t0, 4);
    chk("t4_x1_dat", lg_dat[1], 8'hB2);

    // Reset during beat 2 of a 4-beat packet from source 1
    do_reset();
    for (int k = 0; k < 4; k++) push(1, 8'h40 + k, k == 3);
    step();
    t0 = cyc;
    step();
    rst_nx = 1'b1;
    step();
    clear_q();
    push(0, 8'h50, 1'b1);
    push(1, 8'h60, 1'b1);
    rst_nx = 1'b0;
    step();
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_rdy", 32'(bus.s_ready), 0);
    chk("t5_cnt", 32'(bus.pkt_cnt), 0);
    step();
    chk("t5_grant_id", 32'(bus.m_id), 0);
    chk("t5_grant_rdy", 32'(bus.s_ready), 4'b0001);
    chk("t5_grant_data", 32'(bus.m_data), 8'h50);
    step();
    step();
    chk("t5_second_id", 32'(bus.m_id), 1);
    step();
    chk("t5_cnt_end", 32'(bus.pkt_cnt), 2);

    // Packet counter wrap with single-beat packets
    do_reset();
    step();
    force dut.pkt_cnt_q = 16'hFFFE;
    mcnt = 16'hFFFE;
    step();
    release dut.pkt_cnt_q;
    push(2, 8'h77, 1'b1);
    push(2, 8'h78, 1'b1);
    clear_logs();
    step();
    t0 = cyc;
    chk("t6_preset", 32'(bus.pkt_cnt), 16'hFFFE);
    step();
    step();
    chk("t6_cnt_ffff", 32'(bus.pkt_cnt), 16'hFFFF);
    step();
    step();
    chk("t6_cnt_wrap", 32'(bus.pkt_cnt), 0);
    chk("t6_nbeats", nlg, 2);
    chk("t6_x0_cyc", lg_cyc[0] - t0, 1);
    chk("t6_x1_cyc", lg_cyc[1] - t0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
